// File: rtl/compress_pkg.sv
// Shared types and width helpers for the compression-mode decision engine.
package compress_pkg;

   typedef enum logic [1:0] {IDLE, COLLECT, EVAL, HOLD} state_t;

   localparam int MODE_TOWER_BIT = 0;
   localparam int MODE_SENSE_BIT = 1;

   function automatic int slice_cnt_w(input int num_counter, input int num_slice);
      return $clog2(num_counter / num_slice + 1);
   endfunction

   function automatic int total_cnt_w(input int num_counter);
      return $clog2(num_counter + 1);
   endfunction

endpackage

// File: rtl/slice_stat_acc.sv
// Per-slice overflow / nonzero saturating counters; updates on the en cycle.
// No handshake of its own: the parent gates en with the accepted beat.
module slice_stat_acc #(
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic          inc_ovf,
   input  logic          inc_nz,
   output logic [CW-1:0] ovf,
   output logic [CW-1:0] nz
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= '0;
         nz  <= '0;
      end else if (clr) begin
         ovf <= '0;
         nz  <= '0;
      end else if (en) begin
         if (inc_ovf && (ovf != '1)) ovf <= ovf + CW'(1);
         if (inc_nz && (nz != '1))   nz  <= nz + CW'(1);
      end
   end

endmodule

// File: rtl/compress_engine.sv
// Per-frame TowerEncoding / SketchSensing decision; Out_valid 2 cycles after last beat,
// result held under Out_ready backpressure. COMPRESS_STATS_EN adds handshake statistics counters.
module compress_engine
   import compress_pkg::*;
#(
   parameter int CNT_W         = 32,
   parameter int NUM_COUNTER   = 10,
   parameter int NUM_SLICE     = 2,
   parameter int THRESHOLD     = 20,
   parameter int TOWER_MAX_OVF = 1,
   parameter int SENSE_COL     = 3
) (
   input  logic                                  SYS_CLK,
   input  logic                                  RESET,
   input  logic [1:0]                            Mode,
   input  logic                                  Start,
   output logic                                  Busy,
   input  logic                                  In_valid,
   output logic                                  In_ready,
   input  logic [CNT_W-1:0]                      Counter,
   output logic                                  Out_valid,
   input  logic                                  Out_ready,
   output logic                                  Flag_TowerEncoding,
   output logic                                  Flag_SketchSensing,
   output logic [total_cnt_w(NUM_COUNTER)-1:0]   Overflow_cnt
`ifdef COMPRESS_STATS_EN
   ,
   output logic [31:0]                           Frame_cnt,
   output logic [31:0]                           Tower_pass_cnt,
   output logic [31:0]                           Sense_pass_cnt
`endif
);

   localparam int SLICE_LEN = NUM_COUNTER / NUM_SLICE;
   localparam int SC_W      = slice_cnt_w(NUM_COUNTER, NUM_SLICE);
   localparam int OVF_W     = total_cnt_w(NUM_COUNTER);
   localparam logic [OVF_W-1:0] LAST_IDX = OVF_W'(NUM_COUNTER - 1);

   generate
      if (NUM_COUNTER % NUM_SLICE != 0) begin : g_bad_cfg
         $error("NUM_COUNTER must be a multiple of NUM_SLICE");
      end
   endgenerate

   state_t           state;
   logic [1:0]       mode_q;
   logic [OVF_W-1:0] idx;
   logic [OVF_W-1:0] ovf_total;
   logic             beat, is_ovf, is_nz, frame_start;
   logic             tower_ok, sense_ok;
   logic [SC_W-1:0]  ovf_s [NUM_SLICE];
   logic [SC_W-1:0]  nz_s  [NUM_SLICE];

   assign beat        = In_valid & In_ready;
   assign is_ovf      = Counter > CNT_W'(THRESHOLD);
   assign is_nz       = |Counter;
   assign frame_start = (state == IDLE) && Start && (Mode != 2'b00);

   for (genvar s = 0; s < NUM_SLICE; s++) begin : g_slice
      slice_stat_acc #(.CW(SC_W)) u_acc (
         .clk     (SYS_CLK),
         .rst     (RESET),
         .clr     (frame_start),
         .en      (beat && ((int'(idx) / SLICE_LEN) == s)),
         .inc_ovf (is_ovf),
         .inc_nz  (is_nz),
         .ovf     (ovf_s[s]),
         .nz      (nz_s[s])
      );
   end

   always_comb begin
      tower_ok = 1'b1;
      sense_ok = 1'b1;
      for (int s = 0; s < NUM_SLICE; s++) begin
         if (int'(ovf_s[s]) > TOWER_MAX_OVF) tower_ok = 1'b0;
         if (int'(nz_s[s]) > SENSE_COL)      sense_ok = 1'b0;
      end
   end

   // Result registers load only in EVAL, so they keep the last frame's answer until the next one.
   always_ff @(posedge SYS_CLK or posedge RESET) begin
      if (RESET) begin
         state              <= IDLE;
         mode_q             <= '0;
         idx                <= '0;
         ovf_total          <= '0;
         Busy               <= 1'b0;
         In_ready           <= 1'b0;
         Out_valid          <= 1'b0;
         Flag_TowerEncoding <= 1'b0;
         Flag_SketchSensing <= 1'b0;
         Overflow_cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (frame_start) begin
                  state     <= COLLECT;
                  mode_q    <= Mode;
                  idx       <= '0;
                  ovf_total <= '0;
                  Busy      <= 1'b1;
                  In_ready  <= 1'b1;
               end
            end
            COLLECT: begin
               if (beat) begin
                  ovf_total <= ovf_total + OVF_W'(is_ovf);
                  if (idx == LAST_IDX) begin
                     state    <= EVAL;
                     In_ready <= 1'b0;
                  end else begin
                     idx <= idx + OVF_W'(1);
                  end
               end
            end
            EVAL: begin
               Flag_TowerEncoding <= tower_ok & mode_q[MODE_TOWER_BIT];
               Flag_SketchSensing <= sense_ok & mode_q[MODE_SENSE_BIT];
               Overflow_cnt       <= ovf_total;
               Out_valid          <= 1'b1;
               state              <= HOLD;
            end
            HOLD: begin
               if (Out_ready) begin
                  Out_valid <= 1'b0;
                  Busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef COMPRESS_STATS_EN
   always_ff @(posedge SYS_CLK or posedge RESET) begin
      if (RESET) begin
         Frame_cnt      <= '0;
         Tower_pass_cnt <= '0;
         Sense_pass_cnt <= '0;
      end else if (Out_valid && Out_ready) begin
         Frame_cnt <= Frame_cnt + 32'd1;
         if (Flag_TowerEncoding) Tower_pass_cnt <= Tower_pass_cnt + 32'd1;
         if (Flag_SketchSensing) Sense_pass_cnt <= Sense_pass_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_compress_engine.sv
// Scoreboard bench for compress_engine: directed frames push expected results, a monitor checks each output handshake.
module tb_compress_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  mode;
   logic        start;
   logic        busy;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] counter;
   logic        out_valid;
   logic        out_ready;
   logic        f_tower;
   logic        f_sense;
   logic [3:0]  ovf_cnt;

   typedef struct {
      logic t;
      logic s;
      int   o;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   int d1[10] = '{0, 25, 0, 0, 3, 1, 2, 0, 0, 0};
   int d2[10] = '{21, 22, 0, 0, 0, 0, 0, 0, 0, 0};
   int d3[10] = '{20, 1, 1, 1, 1, 0, 0, 0, 0, 0};

   always #5 clk = ~clk;

   compress_engine dut (
      .SYS_CLK            (clk),
      .RESET              (rst),
      .Mode               (mode),
      .Start              (start),
      .Busy               (busy),
      .In_valid           (in_valid),
      .In_ready           (in_ready),
      .Counter            (counter),
      .Out_valid          (out_valid),
      .Out_ready          (out_ready),
      .Flag_TowerEncoding (f_tower),
      .Flag_SketchSensing (f_sense),
      .Overflow_cnt       (ovf_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, req);
      end
   endtask

   // Monitor: every output handshake must match the oldest expected result.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected output", 32'(out_valid), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("tower flag", 32'(f_tower), 32'(e.t));
            check("sense flag", 32'(f_sense), 32'(e.s));
            check("overflow cnt", 32'(ovf_cnt), 32'(e.o));
         end
      end
   end

   task automatic send_frame(input logic [1:0] m, input int v[10], input logic et,
                             input logic es, input int eo, input string tag);
      exp_t e;
      int   lat;
      @(posedge clk); #1;
      mode  = m;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      mode  = ~m;
      e.t = et;
      e.s = es;
      e.o = eo;
      exp_q.push_back(e);
      for (int i = 0; i < 10; i++) begin
         int w;
         w        = 0;
         in_valid = 1'b1;
         counter  = 32'(v[i]);
         @(negedge clk);
         while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
         end
         if (!in_ready) begin
            check({tag, " in_ready timeout"}, 32'(in_ready), 32'd1);
            break;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      counter  = '0;
      lat      = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) check({tag, " in_ready drop"}, 32'(in_ready), 32'd0);
      end while (!out_valid && lat < 20);
      check({tag, " latency"}, 32'(lat), 32'd2);
   endtask

   initial begin
      rst       = 1'b1;
      mode      = 2'b00;
      start     = 1'b0;
      in_valid  = 1'b0;
      counter   = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset busy", 32'(busy), 32'd0);
      check("reset in_ready", 32'(in_ready), 32'd0);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset tower", 32'(f_tower), 32'd0);
      check("reset sense", 32'(f_sense), 32'd0);
      check("reset ovf", 32'(ovf_cnt), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      send_frame(2'b11, d1, 1'b1, 1'b1, 1, "f1");
      send_frame(2'b11, d2, 1'b0, 1'b1, 2, "f2");
      send_frame(2'b11, d3, 1'b1, 1'b0, 0, "f3");
      send_frame(2'b01, d1, 1'b1, 1'b0, 1, "f4");

      // Mode 00 start is ignored; a stray In_valid in IDLE consumes nothing.
      @(posedge clk); #1;
      mode     = 2'b00;
      start    = 1'b1;
      in_valid = 1'b1;
      counter  = 32'd99;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("mode00 busy", 32'(busy), 32'd0);
      check("mode00 in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;

      // Backpressure: result held for 5 cycles with a Start pulse ignored.
      out_ready = 1'b0;
      send_frame(2'b11, d2, 1'b0, 1'b1, 2, "bp");
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         start = (c == 1);
         mode  = 2'b11;
         @(negedge clk);
         check("bp out_valid", 32'(out_valid), 32'd1);
         check("bp tower", 32'(f_tower), 32'd0);
         check("bp sense", 32'(f_sense), 32'd1);
         check("bp ovf", 32'(ovf_cnt), 32'd2);
         check("bp in_ready", 32'(in_ready), 32'd0);
         check("bp busy", 32'(busy), 32'd1);
      end
      @(posedge clk); #1;
      start     = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      check("post-hs busy", 32'(busy), 32'd0);
      check("post-hs out_valid", 32'(out_valid), 32'd0);
      check("post-hs in_ready", 32'(in_ready), 32'd0);
      check("post-hs ovf hold", 32'(ovf_cnt), 32'd2);
      check("post-hs sense hold", 32'(f_sense), 32'd1);

      send_frame(2'b10, d1, 1'b0, 1'b1, 1, "f6");

      // Reset after 4 of 10 beats discards the partial frame.
      @(posedge clk); #1;
      mode  = 2'b11;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         counter  = 32'(d2[i]);
         @(negedge clk);
         check("partial in_ready", 32'(in_ready), 32'd1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst in_ready", 32'(in_ready), 32'd0);
      check("midrst out_valid", 32'(out_valid), 32'd0);
      check("midrst tower", 32'(f_tower), 32'd0);
      check("midrst sense", 32'(f_sense), 32'd0);
      check("midrst ovf", 32'(ovf_cnt), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      send_frame(2'b11, d2, 1'b0, 1'b1, 2, "f7");

      for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(negedge clk);
      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
